uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares a single UART `Transmitter` among `NUM_CLIENTS` byte producers. It accepts one byte per grant and drives the transmitter's `tx_start`/`tx_data_in`. It then holds off all clients until the transmitter reports `tx_done`, or until a watchdog expires. It sits directly in front of the `Transmitter` instance, and both blocks share `clk` and `reset`.

## Interface
- `NUM_CLIENTS`, 4, number of requesters (≥2)
- `DATA_BITS`, 8, byte width; must match the transmitter
- `TIMEOUT_CYCLES`, 256, maximum `clk` cycles spent in WAIT before abort (≥2)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  NUM_CLIENTS  per-client request level
- `req_data`  in  NUM_CLIENTS*DATA_BITS  client i byte at bits [i*DATA_BITS +: DATA_BITS]
- `ack`  out  NUM_CLIENTS  one-cycle pulse: client's byte accepted
- `tx_start`  out  1  one-cycle start pulse to transmitter
- `tx_data`  out  DATA_BITS  byte to transmitter; stable from `tx_start` until back in IDLE
- `tx_done`  in  1  transmitter completion pulse
- `busy`  out  1  high while a frame is in flight (state WAIT)
- `active_id`  out  $clog2(NUM_CLIENTS)  index of the client currently or last granted
- `timeout_err`  out  1  one-cycle pulse: watchdog abort

## Operation
- States: IDLE, WAIT. All outputs are registered.
- Reset values:
  - state IDLE
  - `ack`=0, `tx_start`=0, `tx_data`=0, `busy`=0, `active_id`=0, `timeout_err`=0
  - round-robin pointer `last`=NUM_CLIENTS-1, so client 0 wins first
  - watchdog counter 0
- IDLE, `req`≠0:
  - Winner w is the first asserted `req` searching from (`last`+1) mod NUM_CLIENTS upward with wrap.
  - On that edge: `tx_data`←byte w, `active_id`←w, `ack[w]`←1, `tx_start`←1, `busy`←1, counter←0, state←WAIT.
- IDLE, `req`=0: stay. `tx_done` in IDLE is ignored.
- WAIT:
  - `ack` and `tx_start` return to 0 after one cycle.
  - The counter increments each cycle.
  - If `tx_done`=1: state←IDLE, `busy`←0, `last`←`active_id`.
  - Else if counter==TIMEOUT_CYCLES-1: `timeout_err`←1 for one cycle, state←IDLE, `busy`←0, `last`←`active_id`.
  - If `tx_done` and the timeout condition occur in the same cycle, done takes priority and no error is raised.
- Client rule: hold `req` and `req_data` stable until `ack`. The cycle after `ack`, either deassert `req` or present the next byte. Any `req` still high when the arbiter is next in IDLE counts as a new request.
- A request arriving during WAIT is not lost. It is evaluated at the next IDLE cycle.
- Reset mid-frame forces all values to reset state immediately. The transmitter is reset by the same signal.

## Timing
- Request to grant: `req` sampled at edge k while in IDLE → `ack` and `tx_start` high during cycle k+1.
- `tx_done` sampled at edge m → `busy` low from m+1. The earliest next `tx_start` is at m+2, which guarantees one idle cycle between frames. The transmitter is already in its IDLE state at that point.
- Timeout: with no `tx_done`, `timeout_err` rises TIMEOUT_CYCLES cycles after `tx_start`.
- Fairness: with all clients requesting continuously, grants rotate 0,1,2,…,N-1,0. No client waits more than N-1 frames.

## Structure
- Shared package `uart_pkg`:
  - `arb_state_t` enum {IDLE, WAIT}
  - the transmitter's `state_t`
  - default `DATA_BITS`
- One natural sub-module: `uart_rr_picker`, a combinational round-robin priority encoder.
  - Inputs: `req`, `last`.
  - Outputs: `grant_valid`, `grant_id`.
  - Implement as a rotate, then priority-find-first, then un-rotate.

## Test plan
- Single request: after reset, `req`=4'b0100 with byte 0xA5 → `ack`=4'b0100 and `tx_start` in the same cycle, `tx_data`=0xA5, `active_id`=2, `busy` high until 1 cycle after `tx_done`.
- Round-robin: `req`=4'b1111 held with 4 distinct bytes, `tx_done` pulsed 20 cycles after each `tx_start` → grant order 0,1,2,3,0 and `tx_data` matches each client's byte.
- Request during WAIT: client 1 requests while client 0 is in flight → no `ack[1]` before `tx_done`; `ack[1]` arrives exactly 2 cycles after `tx_done`.
- Watchdog: TIMEOUT_CYCLES=16, `tx_done` never asserted → `timeout_err` pulses once 16 cycles after `tx_start`, `busy` drops, and the next request is granted normally.
- Done/timeout collision and spurious done: `tx_done` on the timeout cycle → no `timeout_err`. `tx_done` in IDLE → no state change.
- Reset mid-frame: assert `reset` during WAIT → all outputs at reset values immediately. After release, client 0 has priority over the others.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  // Transmitter FSM encoding; prefixed so it can share scope with arb_state_t.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin priority encoder: rotate so (last+1) sits at bit 0,
// find the first set bit, then map the offset back to a client index.
module uart_rr_picker #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [ID_W-1:0]        last,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id
);

  logic [NUM_CLIENTS-1:0] rot;
  int unsigned            offset;

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      rot[i] = req[(32'(last) + 1 + i) % NUM_CLIENTS];
    end

    // Scan downward so the lowest set offset is the one left standing.
    offset      = 0;
    grant_valid = 1'b0;
    for (int unsigned i = NUM_CLIENTS; i > 0; i--) begin
      if (rot[i-1]) begin
        grant_valid = 1'b1;
        offset      = i - 1;
      end
    end

    grant_id = ID_W'((32'(last) + 1 + offset) % NUM_CLIENTS);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among several byte producers,
// with a watchdog that aborts a frame whose tx_done never arrives.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned DATA_BITS      = UART_DATA_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           req,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]           ack,
  output logic                             tx_start,
  output logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_done,
  output logic                             busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]   active_id,
  output logic                             timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_CLIENTS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t             state_q;
  logic [ID_W-1:0]        last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_CLIENTS-1:0] ack_q;
  logic                   tx_start_q;
  logic [DATA_BITS-1:0]   tx_data_q;
  logic                   busy_q;
  logic [ID_W-1:0]        active_id_q;
  logic                   timeout_err_q;

  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic [DATA_BITS-1:0]   grant_byte_d;

  uart_rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .ID_W        (ID_W)
  ) u_picker (
    .req         (req),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant_byte_d = req_data[32'(grant_id)*DATA_BITS +: DATA_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= ID_W'(NUM_CLIENTS - 1);
      cnt_q         <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      active_id_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            tx_data_q   <= grant_byte_d;
            active_id_q <= grant_id;
            ack_q       <= NUM_CLIENTS'(1) << grant_id;
            tx_start_q  <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Completion wins over a watchdog expiry landing on the same cycle.
          if (tx_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            last_q  <= active_id_q;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            last_q        <= active_id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign active_id   = active_id_q;
  assign timeout_err = timeout_err_q;

endmodule
